// File: rtl/t06_lcd_pkg.sv
// Shared types and constants for the 8080-style LCD bus writer.
// The init-sequence states exist only when T06_LCD_INIT_EN is defined.
package t06_lcd_pkg;

  localparam int WR_LOW_CYC_DEF  = 2;
  localparam int WR_HIGH_CYC_DEF = 2;
  localparam int DELAY_UNIT_DEF  = 10;

  localparam logic [1:0] ROM_CMD   = 2'b00;
  localparam logic [1:0] ROM_DATA  = 2'b01;
  localparam logic [1:0] ROM_DELAY = 2'b10;
  localparam logic [1:0] ROM_END   = 2'b11;

  localparam int ROM_AW = 4;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] val;
  } rom_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WR_LO,
`ifdef T06_LCD_INIT_EN
    S_WR_HI,
    S_INIT_FETCH,
    S_INIT_WAIT
`else
    S_WR_HI
`endif
  } state_t;

endpackage

// File: rtl/t06_lcd_init_rom.sv
// Power-up command table for the LCD bus writer (T06_LCD_INIT_EN builds).
// Entries are {type[1:0], byte[7:0]}; unused slots read as end markers.
module t06_lcd_init_rom
  import t06_lcd_pkg::*;
(
  input  logic [ROM_AW-1:0] idx,
  output logic [9:0]        entry
);

  always_comb begin
    entry = {ROM_END, 8'h00};
    case (idx)
      4'd0:    entry = {ROM_CMD,   8'h01};
      4'd1:    entry = {ROM_DELAY, 8'd5};
      4'd2:    entry = {ROM_CMD,   8'h11};
      default: entry = {ROM_END,   8'h00};
    endcase
  end

endmodule

// File: rtl/t06_lcd_bus_writer.sv
// 8080 parallel LCD write engine: SETUP / WR_LO / WR_HI byte timing.
// Optional ROM-driven power-up sequence under T06_LCD_INIT_EN.
module t06_lcd_bus_writer
  import t06_lcd_pkg::*;
#(
  parameter int WR_LOW_CYC  = WR_LOW_CYC_DEF,
  parameter int WR_HIGH_CYC = WR_HIGH_CYC_DEF,
  parameter int DELAY_UNIT  = DELAY_UNIT_DEF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       in_valid,
  input  logic       in_dcx,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] d,
  output logic       wr,
  output logic       dcx,
  output logic       busy,
  output logic       init_done
);

  if (WR_LOW_CYC < 1 || WR_HIGH_CYC < 1 || DELAY_UNIT < 1) begin : g_bad
    $error("t06_lcd_bus_writer: timing parameters must be >= 1");
  end

`ifdef T06_LCD_INIT_EN
  localparam int DLY_MAX = 255 * DELAY_UNIT;
`else
  localparam int DLY_MAX = 0;
`endif
  localparam int M1 =
    (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int MAXC = (M1 > DLY_MAX) ? M1 : DLY_MAX;
  localparam int CW = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  // The IDLE cycle that follows WR_HI is the last high cycle of the
  // strobe (data still held), so WR_HI itself lasts one cycle less.
  localparam int HI_LOAD = (WR_HIGH_CYC > 1) ? WR_HIGH_CYC - 2 : 0;

  state_t        state;
  state_t        state_n;
  state_t        done_st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_load;
  logic          accept;

  assign accept = in_valid & in_ready;

`ifdef T06_LCD_INIT_EN
  logic [ROM_AW-1:0] idx;
  logic [9:0]        ent_raw;
  rom_entry_t        ent;
  logic              done_r;
  logic [CW-1:0]     dly_load;

  t06_lcd_init_rom u_rom (
    .idx   (idx),
    .entry (ent_raw)
  );

  assign ent       = rom_entry_t'(ent_raw);
  assign init_done = done_r;
  assign done_st   = done_r ? S_IDLE : S_INIT_FETCH;
  assign dly_load  = CW'(int'(ent.val) * DELAY_UNIT - 1);
`else
  assign init_done = 1'b1;
  assign done_st   = S_IDLE;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
`ifdef T06_LCD_INIT_EN
      state <= S_INIT_FETCH;
`else
      state <= S_IDLE;
`endif
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_SETUP;
      S_SETUP: state_n = S_WR_LO;
      S_WR_LO:
        if (cnt == '0)
          state_n = (WR_HIGH_CYC > 1) ? S_WR_HI : done_st;
      S_WR_HI: if (cnt == '0) state_n = done_st;
`ifdef T06_LCD_INIT_EN
      S_INIT_FETCH:
        unique case (1'b1)
          !ent.typ[1]:
            state_n = S_SETUP;
          ent.typ == ROM_DELAY:
            state_n = (ent.val == 8'd0) ? S_INIT_FETCH : S_INIT_WAIT;
          default:
            state_n = S_IDLE;
        endcase
      S_INIT_WAIT: if (cnt == '0) state_n = S_INIT_FETCH;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    unique case (state_n)
      S_WR_LO:     cnt_load = CW'(WR_LOW_CYC - 1);
      S_WR_HI:     cnt_load = CW'(HI_LOAD);
`ifdef T06_LCD_INIT_EN
      S_INIT_WAIT: cnt_load = dly_load;
`endif
      default:     cnt_load = '0;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE) & enable & init_done;
    wr       = (state != S_WR_LO);
    busy     = nrst & (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= cnt_load;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d   <= 8'h00;
      dcx <= 1'b1;
`ifdef T06_LCD_INIT_EN
      idx    <= '0;
      done_r <= 1'b0;
`endif
    end else begin
      if (accept) begin
        d   <= in_data;
        dcx <= in_dcx;
      end
`ifdef T06_LCD_INIT_EN
      if (state == S_INIT_FETCH) begin
        unique case (1'b1)
          !ent.typ[1]: begin
            d   <= ent.val;
            dcx <= ent.typ[0];
            idx <= idx + 1'b1;
          end
          ent.typ == ROM_DELAY: idx <= idx + 1'b1;
          default:              done_r <= 1'b1;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_t06_lcd_bus_writer.sv
// Directed bench for t06_lcd_bus_writer with a byte scoreboard.
// Covers the T06_LCD_INIT_EN sequence when that macro is defined.
module tb_t06_lcd_bus_writer;
  import t06_lcd_pkg::*;

  localparam int LO = 2;
  localparam int HI = 2;
  localparam int DU = 10;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_dcx = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] d;
  logic       wr;
  logic       dcx;
  logic       busy;
  logic       init_done;

  t06_lcd_bus_writer #(
    .WR_LOW_CYC  (LO),
    .WR_HIGH_CYC (HI),
    .DELAY_UNIT  (DU)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_dcx    (in_dcx),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .d         (d),
    .wr        (wr),
    .dcx       (dcx),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [8:0] sb[$];
  int rise_t[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: checks each completed wr pulse against the scoreboard.
  logic       prev_wr = 1'b1;
  int         lo_cnt = 0;
  int         cyc = 0;
  logic [8:0] lo_bus;
  logic [8:0] exp_bus;

  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      prev_wr = 1'b1;
      lo_cnt  = 0;
    end else begin
      if (!wr) begin
        if (prev_wr) lo_bus = {dcx, d};
        else chk("bus_stable", {dcx, d}, lo_bus);
        lo_cnt++;
      end else if (!prev_wr) begin
        chk("wr_low_len", lo_cnt, LO);
        rise_t.push_back(cyc);
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_bus = sb.pop_front();
          chk("pop_bus", {dcx, d}, exp_bus);
        end
        lo_cnt = 0;
      end
      prev_wr = wr;
    end
  end

`ifdef T06_LCD_INIT_EN
  initial begin
    enable = 1'b0;
    #12;
    chk("rst_d", d, 8'h00);
    chk("rst_wr", wr, 1'b1);
    chk("rst_dcx", dcx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h11});
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (init_done) break;
      chk("init_ready_low", in_ready, 1'b0);
    end
    chk("init_done", init_done, 1'b1);
    chk("init_pulses", rise_t.size(), 2);
    if (rise_t.size() == 2)
      chk("init_gap", rise_t[1] - rise_t[0], 1 + 1 + 5 * DU + 1 + 1 + LO);
    chk("init_sb_empty", sb.size(), 0);
    enable = 1'b1;
    #1;
    chk("init_ready_after", in_ready, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
`else
  logic [4:0] ew;
  logic [4:0] er;
  logic [4:0] eb;
  logic [7:0] vals[4];

  initial begin
    ew = 5'b11001;
    er = 5'b10000;
    eb = 5'b01111;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    enable = 1'b1;
    #12;
    chk("rst_d", d, 8'h00);
    chk("rst_wr", wr, 1'b1);
    chk("rst_dcx", dcx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // single command byte
    in_valid = 1'b1;
    in_dcx   = 1'b0;
    in_data  = 8'h2C;
    sb.push_back({1'b0, 8'h2C});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid = 1'b0;
        chk("one_d", d, 8'h2C);
        chk("one_dcx", dcx, 1'b0);
      end
      chk("one_wr", wr, ew[i-1]);
      chk("one_ready", in_ready, er[i-1]);
      chk("one_busy", busy, eb[i-1]);
    end

    // back-to-back data stream
    in_dcx = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data  = vals[k];
      in_valid = 1'b1;
      chk("b2b_ready", in_ready, 1'b1);
      sb.push_back({1'b1, vals[k]});
      for (int j = 1; j <= 5; j++) begin
        @(negedge clk);
        if (j < 5) chk("b2b_ready_low", in_ready, 1'b0);
      end
    end
    in_valid = 1'b0;
    chk("b2b_rises", rise_t.size(), 5);
    for (int k = 2; k <= 4; k++)
      if (rise_t.size() == 5)
        chk("b2b_period", rise_t[k] - rise_t[k-1], 5);
    chk("b2b_sb_empty", sb.size(), 0);

    // enable drops during WR_LO
    in_data  = 8'h5A;
    in_dcx   = 1'b1;
    in_valid = 1'b1;
    chk("en_ready", in_ready, 1'b1);
    sb.push_back({1'b1, 8'h5A});
    @(negedge clk);
    in_data = 8'hA5;
    in_dcx  = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    for (int j = 3; j <= 10; j++) begin
      @(negedge clk);
      chk("en_ready_low", in_ready, 1'b0);
      chk("en_busy", busy, j < 5);
    end
    chk("en_sb_done", sb.size(), 0);
    chk("en_d_held", d, 8'h5A);
    enable = 1'b1;
    #1;
    chk("en_ready_back", in_ready, 1'b1);
    sb.push_back({1'b0, 8'hA5});
    @(negedge clk);
    in_valid = 1'b0;
    chk("en_next_d", d, 8'hA5);
    repeat (4) @(negedge clk);
    chk("en_sb_empty", sb.size(), 0);

    // reset while wr is low
    in_data  = 8'h77;
    in_dcx   = 1'b0;
    in_valid = 1'b1;
    sb.push_back({1'b0, 8'h77});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rmid_wr_low", wr, 1'b0);
    #1 nrst = 1'b0;
    #1;
    chk("rmid_wr", wr, 1'b1);
    chk("rmid_d", d, 8'h00);
    chk("rmid_dcx", dcx, 1'b1);
    chk("rmid_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    #2 nrst = 1'b1;
    in_data  = 8'h99;
    in_dcx   = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("rrel_ready", in_ready, 1'b1);
    sb.push_back({1'b1, 8'h99});
    @(negedge clk);
    in_valid = 1'b0;
    chk("rrel_busy", busy, 1'b1);
    chk("rrel_d", d, 8'h99);
    repeat (4) @(negedge clk);
    chk("rrel_ready_again", in_ready, 1'b1);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
`endif

endmodule
